// File: rtl/ccc_lock_supervisor.sv
// ---------------------------------------------------------------------------
// ccc_lock_supervisor
//
// Lock supervisor and reset sequencer for one PF_CCC PLL with up to four
// fabric clock outputs. Runs on the free-running reference clock that also
// feeds the PLL. It:
//   - holds the PLL in power-down for PD_CYCLES, then waits for lock,
//   - qualifies the synchronised lock for LOCK_STABLE_CYCLES,
//   - enables the PLL outputs and releases the per-domain resets staggered
//     by STAGGER_CYCLES, lowest index first,
//   - retries power-down/re-lock on timeout up to MAX_RETRIES, then faults,
//   - drops everything and re-acquires if lock is lost after qualification.
//
// Ports:
//   CLK              reference clock, all logic on its rising edge
//   RESET            synchronous, active-high reset (overrides RESTART)
//   PLL_LOCK         raw PLL lock, asynchronous to CLK
//   RESTART          one-cycle request to restart the whole sequence
//   PLL_POWERDOWN_N  to PLL POWERDOWN_N
//   OUT_EN           to PLL OUTx_EN, one bit per supervised output
//   DOMAIN_RESET_N   active-low reset per output clock domain (resync locally)
//   ALL_READY        every domain released and running
//   LOCK_LOST        one-cycle pulse when a qualified lock drops
//   FAULT            retries exhausted; only RESTART or RESET leave it
//   RETRY_COUNT      power-down/re-lock attempts used in this sequence
//
// Every output is a flop; the next-state logic computes the value each
// output takes after the coming edge, so no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module ccc_lock_supervisor #(
    parameter int NUM_OUT             = 2,
    parameter int PD_CYCLES           = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 16,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PLL_LOCK,
    input  logic               RESTART,
    output logic               PLL_POWERDOWN_N,
    output logic [NUM_OUT-1:0] OUT_EN,
    output logic [NUM_OUT-1:0] DOMAIN_RESET_N,
    output logic               ALL_READY,
    output logic               LOCK_LOST,
    output logic               FAULT,
    output logic [1:0]         RETRY_COUNT
);

    // The release phase lasts until cnt reaches NUM_OUT*STAGGER_CYCLES,
    // the cycle after the last domain comes out of reset.
    localparam int REL_END = NUM_OUT * STAGGER_CYCLES;

    // One shared counter sized for the largest terminal value in any state.
    localparam int MAX_AB  = (PD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             PD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > REL_END) ?
                             LOCK_STABLE_CYCLES : REL_END;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_END);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PWRDN     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_clr;

    logic               lock_meta;
    logic               lock_s;

    logic               pd_n_nxt;
    logic [NUM_OUT-1:0] out_en_nxt;
    logic [NUM_OUT-1:0] rst_n_nxt;
    logic               ready_nxt;
    logic               lost_nxt;
    logic               fault_nxt;
    logic [1:0]         retry_nxt;

    // Two-flop synchroniser for the asynchronous PLL lock. Cleared by RESET
    // so that a fresh sequence never sees a stale lock.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= PLL_LOCK;
            lock_s    <= lock_meta;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        lost_nxt  = 1'b0;
        retry_nxt = RETRY_COUNT;
        rst_n_nxt = DOMAIN_RESET_N;

        case (state)
            S_PWRDN: begin
                if (cnt == PD_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                end
            end

            S_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle still counts as lock.
                if (lock_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TO_LAST) begin
                    if (RETRY_COUNT == RETRY_LIMIT) begin
                        state_nxt = S_FAULT;
                    end else begin
                        retry_nxt = RETRY_COUNT + 2'd1;
                        state_nxt = S_PWRDN;
                    end
                end
            end

            S_STABLE: begin
                // A drop on the qualifying cycle wins over the release.
                // Returning to WAIT_LOCK restarts the timeout at no retry cost.
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == ST_LAST) begin
                    state_nxt = S_RELEASE;
                end
            end

            S_RELEASE: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                    lost_nxt  = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_OUT; i++) begin
                        if (cnt == CNT_W'((i + 1) * STAGGER_CYCLES - 1)) begin
                            rst_n_nxt[i] = 1'b1;
                        end
                    end
                    if (cnt == REL_LAST) begin
                        state_nxt = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                    lost_nxt  = 1'b1;
                end
            end

            S_FAULT: begin
                state_nxt = S_FAULT;
            end

            default: begin
                state_nxt = S_PWRDN;
            end
        endcase

        // RESTART wins over every state decision; RESET is handled in the
        // register block and wins over RESTART.
        if (RESTART) begin
            state_nxt = S_PWRDN;
            retry_nxt = 2'd0;
            lost_nxt  = 1'b0;
            cnt_clr   = 1'b1;
        end

        if (state_nxt != state) begin
            cnt_clr = 1'b1;
        end

        // Reaching RUN means the attempt succeeded, so the budget is refunded.
        if (state_nxt == S_RUN) begin
            retry_nxt = 2'd0;
        end

        // Domain resets are only held released while the outputs are live;
        // leaving RELEASE/RUN for any reason re-asserts them on the same edge.
        if (!(state_nxt inside {S_RELEASE, S_RUN})) begin
            rst_n_nxt = '0;
        end

        pd_n_nxt   = state_nxt inside {S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN};
        out_en_nxt = {NUM_OUT{state_nxt inside {S_RELEASE, S_RUN}}};
        ready_nxt  = (state_nxt == S_RUN);
        fault_nxt  = (state_nxt == S_FAULT);
    end

    // State, counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= S_PWRDN;
            cnt             <= '0;
            PLL_POWERDOWN_N <= 1'b0;
            OUT_EN          <= '0;
            DOMAIN_RESET_N  <= '0;
            ALL_READY       <= 1'b0;
            LOCK_LOST       <= 1'b0;
            FAULT           <= 1'b0;
            RETRY_COUNT     <= 2'd0;
        end else begin
            state <= state_nxt;
            // The counter saturates so long stays in RUN/FAULT never wrap
            // back onto a terminal value.
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
            PLL_POWERDOWN_N <= pd_n_nxt;
            OUT_EN          <= out_en_nxt;
            DOMAIN_RESET_N  <= rst_n_nxt;
            ALL_READY       <= ready_nxt;
            LOCK_LOST       <= lost_nxt;
            FAULT           <= fault_nxt;
            RETRY_COUNT     <= retry_nxt;
        end
    end

endmodule

// File: tb/tb_ccc_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_ccc_lock_supervisor
//
// Directed bench for ccc_lock_supervisor. Three instances (NUM_OUT = 2, 1, 4)
// share clock, reset and stimulus so the release ordering is seen for each
// width on the same timeline. Cycle 0 is the first cycle after RESET falls;
// inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ccc_lock_supervisor;

    logic       CLK      = 1'b0;
    logic       RESET    = 1'b1;
    logic       PLL_LOCK = 1'b0;
    logic       RESTART  = 1'b0;

    logic       pd2, rdy2, lost2, flt2;
    logic [1:0] oe2, drn2, rc2;
    logic       pd1, rdy1, lost1, flt1;
    logic [0:0] oe1, drn1;
    logic [1:0] rc1;
    logic       pd4, rdy4, lost4, flt4;
    logic [3:0] oe4, drn4;
    logic [1:0] rc4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;

    always #5 CLK = ~CLK;

    ccc_lock_supervisor #(
        .NUM_OUT(2), .PD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES(8), .STAGGER_CYCLES(4), .MAX_RETRIES(1)
    ) dut2 (
        .CLK(CLK), .RESET(RESET), .PLL_LOCK(PLL_LOCK), .RESTART(RESTART),
        .PLL_POWERDOWN_N(pd2), .OUT_EN(oe2), .DOMAIN_RESET_N(drn2),
        .ALL_READY(rdy2), .LOCK_LOST(lost2), .FAULT(flt2), .RETRY_COUNT(rc2)
    );

    ccc_lock_supervisor #(
        .NUM_OUT(1), .PD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES(8), .STAGGER_CYCLES(4), .MAX_RETRIES(1)
    ) dut1 (
        .CLK(CLK), .RESET(RESET), .PLL_LOCK(PLL_LOCK), .RESTART(RESTART),
        .PLL_POWERDOWN_N(pd1), .OUT_EN(oe1), .DOMAIN_RESET_N(drn1),
        .ALL_READY(rdy1), .LOCK_LOST(lost1), .FAULT(flt1), .RETRY_COUNT(rc1)
    );

    ccc_lock_supervisor #(
        .NUM_OUT(4), .PD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES(8), .STAGGER_CYCLES(4), .MAX_RETRIES(1)
    ) dut4 (
        .CLK(CLK), .RESET(RESET), .PLL_LOCK(PLL_LOCK), .RESTART(RESTART),
        .PLL_POWERDOWN_N(pd4), .OUT_EN(oe4), .DOMAIN_RESET_N(drn4),
        .ALL_READY(rdy4), .LOCK_LOST(lost4), .FAULT(flt4), .RETRY_COUNT(rc4)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_to(input int c);
        if (c > cyc) step(c - cyc);
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        RESTART  = 1'b0;
        PLL_LOCK = 1'b0;
        step(3);
        RESET = 1'b0;
        cyc   = 0;
    endtask

    // All outputs of the NUM_OUT=2 instance against one expected set.
    task automatic chk2(input string tag, input logic pd, input logic [1:0] oe,
                        input logic [1:0] drn, input logic rdy, input logic lost,
                        input logic flt, input logic [1:0] rc);
        check($sformatf("%s pd c=%0d", tag, cyc),    32'(pd2),   32'(pd));
        check($sformatf("%s oe c=%0d", tag, cyc),    32'(oe2),   32'(oe));
        check($sformatf("%s drn c=%0d", tag, cyc),   32'(drn2),  32'(drn));
        check($sformatf("%s ready c=%0d", tag, cyc), 32'(rdy2),  32'(rdy));
        check($sformatf("%s lost c=%0d", tag, cyc),  32'(lost2), 32'(lost));
        check($sformatf("%s fault c=%0d", tag, cyc), 32'(flt2),  32'(flt));
        check($sformatf("%s retry c=%0d", tag, cyc), 32'(rc2),   32'(rc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- nominal bring-up, all three widths ----------------
        do_reset();
        for (int c = 0; c <= 45; c++) begin
            wait_to(c);
            chk2("nom", c >= 4, (c >= 25) ? 2'b11 : 2'b00, {c >= 33, c >= 29},
                 c >= 34, 1'b0, 1'b0, 2'd0);
            check($sformatf("nom n1 drn c=%0d", c),   32'(drn1), 32'(c >= 29));
            check($sformatf("nom n1 ready c=%0d", c), 32'(rdy1), 32'(c >= 30));
            check($sformatf("nom n4 oe c=%0d", c),    32'(oe4),  (c >= 25) ? 32'hF : 32'h0);
            check($sformatf("nom n4 drn c=%0d", c),   32'(drn4),
                  32'({c >= 41, c >= 37, c >= 33, c >= 29}));
            check($sformatf("nom n4 ready c=%0d", c), 32'(rdy4), 32'(c >= 42));
            if (c == 14) PLL_LOCK = 1'b1;
        end

        // ---------------- lock loss in RUN, then re-sequence ----------------
        PLL_LOCK = 1'b0;
        pulses   = 0;
        for (int c = 45; c <= 72; c++) begin
            wait_to(c);
            if (lost2) pulses++;
            chk2("loss", 1'b1, (c < 48 || c >= 61) ? 2'b11 : 2'b00,
                 (c < 48) ? 2'b11 : {c >= 69, c >= 65}, c < 48 || c >= 70,
                 c == 48, 1'b0, 2'd0);
            check($sformatf("loss n1 drn c=%0d", c),  32'(drn1), 32'(c < 48 || c >= 65));
            check($sformatf("loss n1 ready c=%0d", c), 32'(rdy1), 32'(c < 48 || c >= 66));
            check($sformatf("loss n4 lost c=%0d", c), 32'(lost4), 32'(c == 48));
            check($sformatf("loss n4 oe c=%0d", c),   32'(oe4),
                  (c < 48 || c >= 61) ? 32'hF : 32'h0);
            if (c == 50) PLL_LOCK = 1'b1;
        end
        check("loss pulse count", 32'(pulses), 32'd1);

        // ---------------- glitchy lock during STABLE ----------------
        do_reset();
        for (int c = 0; c <= 26; c++) begin
            wait_to(c);
            chk2("glitch", c >= 4, (c >= 25) ? 2'b11 : 2'b00, 2'b00,
                 1'b0, 1'b0, 1'b0, 2'd0);
            if (c == 6)  PLL_LOCK = 1'b1;
            if (c == 12) PLL_LOCK = 1'b0;
            if (c == 14) PLL_LOCK = 1'b1;
        end

        // ---------------- timeout, retry, fault ----------------
        do_reset();
        for (int c = 0; c <= 80; c++) begin
            wait_to(c);
            chk2("tmo", (c >= 4 && c < 36) || (c >= 40 && c < 72), 2'b00, 2'b00,
                 1'b0, 1'b0, c >= 72, (c >= 36) ? 2'd1 : 2'd0);
            if (c == 80) RESTART = 1'b1;
        end

        // ---------------- fault recovery via RESTART ----------------
        wait_to(81);
        RESTART = 1'b0;
        for (int c = 81; c <= 111; c++) begin
            wait_to(c);
            chk2("recov", c >= 85, (c >= 101) ? 2'b11 : 2'b00, {c >= 109, c >= 105},
                 c >= 110, 1'b0, 1'b0, 2'd0);
            if (c == 90) PLL_LOCK = 1'b1;
        end

        // ---------------- one retry, then lock: count cleared in RUN --------
        do_reset();
        for (int c = 0; c <= 62; c++) begin
            wait_to(c);
            chk2("rlock", (c >= 4 && c < 36) || c >= 40, (c >= 52) ? 2'b11 : 2'b00,
                 {c >= 60, c >= 56}, c >= 61, 1'b0, 1'b0,
                 (c >= 36 && c < 61) ? 2'd1 : 2'd0);
            if (c == 41) PLL_LOCK = 1'b1;
        end

        // ---------------- RESET + RESTART together mid-RELEASE --------------
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            wait_to(c);
            chk2("rr", c >= 4, (c >= 17) ? 2'b11 : 2'b00, {1'b0, c >= 21},
                 1'b0, 1'b0, 1'b0, 2'd0);
            if (c == 6) PLL_LOCK = 1'b1;
        end
        check("rr n4 drn mid-release", 32'(drn4), 32'h1);
        RESET   = 1'b1;
        RESTART = 1'b1;
        wait_to(23);
        chk2("rr reset", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);
        check("rr n4 drn", 32'(drn4), 32'h0);
        check("rr n4 oe",  32'(oe4),  32'h0);
        check("rr n1 drn", 32'(drn1), 32'h0);
        RESET   = 1'b0;
        RESTART = 1'b0;
        for (int c = 24; c <= 36; c++) begin
            wait_to(c);
            chk2("rr after", c >= 27, (c >= 36) ? 2'b11 : 2'b00, 2'b00,
                 1'b0, 1'b0, 1'b0, 2'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
